// File: rtl/drbg_request_scheduler.sv
// drbg_request_scheduler
//  Sequences the hash_drbg core so that only one command is in flight at a time. Each command
//  is one of INIT, interval RESEED, per-line GENERATE or catch-up RESEED. The block owns the
//  sequence counter (seq_count) and the count of generates since the last seed (gen_count).
//
//  Optional feature: define DRBG_SCHED_WATCHDOG_EN to enable a WAIT-state watchdog. When it
//  expires, the block pulses wd_fault, drops init_done and forces the next grant to INIT.
//  When the macro is undefined, wd_fault is tied to 0.
//
//  Ports
//   clk, reset      clock, synchronous active-high reset
//   init_req        level: (re)instantiate the core
//   catchup_req     level: issue extra reseeds to advance the sequence
//   block_reseed    level: hold off interval reseeds
//   line_req        pulse: one generate needed for the next video line
//   core_busy       core cannot accept a command
//   core_done       pulse: current command finished
//   core_cmd        0 NONE, 1 INIT, 2 GENERATE, 3 RESEED (held while in flight)
//   core_start      pulse: command strobe
//   line_ack        pulse: line generate completed
//   line_miss       pulse: line_req arrived while one was already pending
//   init_done       core instantiated
//   catchup_active  a catch-up reseed is in flight
//   seq_count       completed reseeds since last init (wraps)
//   wd_fault        pulse: watchdog expired
module drbg_request_scheduler #(
  parameter int unsigned GENERATES_PER_RESEED = 480,
  parameter int unsigned SEQ_W                = 32,
  parameter int unsigned TIMEOUT_CYCLES       = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_req,
  input  logic             catchup_req,
  input  logic             block_reseed,
  input  logic             line_req,
  input  logic             core_busy,
  input  logic             core_done,
  output logic [1:0]       core_cmd,
  output logic             core_start,
  output logic             line_ack,
  output logic             line_miss,
  output logic             init_done,
  output logic             catchup_active,
  output logic [SEQ_W-1:0] seq_count,
  output logic             wd_fault
);

  localparam int unsigned GEN_W = $clog2(GENERATES_PER_RESEED + 1);
  localparam logic [GEN_W-1:0] GEN_MAX = GEN_W'(GENERATES_PER_RESEED);

  localparam logic [1:0] CMD_NONE   = 2'd0;
  localparam logic [1:0] CMD_INIT   = 2'd1;
  localparam logic [1:0] CMD_GEN    = 2'd2;
  localparam logic [1:0] CMD_RESEED = 2'd3;

  if (GENERATES_PER_RESEED < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("GENERATES_PER_RESEED and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic {StIdle, StWait} state_e;

  state_e           state;
  logic             line_pending;
  logic [GEN_W-1:0] gen_count;
  logic             init_want;
  logic             reseed_due;
  logic             gen_done;
  logic [1:0]       grant_cmd;
  logic             grant_catchup;

`ifdef DRBG_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic            force_init;
  logic [WD_W-1:0] wd_count;

  // A watchdog expiry forces re-instantiation even without a request.
  assign init_want = init_req | force_init;
`else
  assign init_want = init_req;
  assign wd_fault  = 1'b0;
`endif

  assign reseed_due = (gen_count == GEN_MAX);
  assign gen_done   = (state == StWait) && core_done && (core_cmd == CMD_GEN);

  // Grant decision, highest priority first; only meaningful in IDLE.
  always_comb begin
    grant_cmd     = CMD_NONE;
    grant_catchup = 1'b0;
    if (state == StIdle && !core_busy) begin
      if (init_want) begin
        grant_cmd = CMD_INIT;
      end else if (init_done && reseed_due && !block_reseed) begin
        grant_cmd = CMD_RESEED;
      end else if (init_done && line_pending) begin
        grant_cmd = CMD_GEN;
      end else if (init_done && catchup_req) begin
        grant_cmd     = CMD_RESEED;
        grant_catchup = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= StIdle;
      core_cmd       <= CMD_NONE;
      core_start     <= 1'b0;
      line_ack       <= 1'b0;
      line_miss      <= 1'b0;
      init_done      <= 1'b0;
      catchup_active <= 1'b0;
      seq_count      <= '0;
      line_pending   <= 1'b0;
      gen_count      <= '0;
`ifdef DRBG_SCHED_WATCHDOG_EN
      wd_fault       <= 1'b0;
      force_init     <= 1'b0;
      wd_count       <= '0;
`endif
    end else begin
      core_start <= 1'b0;
      line_ack   <= 1'b0;
`ifdef DRBG_SCHED_WATCHDOG_EN
      wd_fault   <= 1'b0;
`endif
      // A request landing on the completing generate re-arms pending without a miss.
      line_miss <= line_req && line_pending && !gen_done;
      if (line_req) begin
        line_pending <= 1'b1;
      end else if (gen_done) begin
        line_pending <= 1'b0;
      end

      case (state)
        StIdle: begin
          if (grant_cmd != CMD_NONE) begin
            state          <= StWait;
            core_cmd       <= grant_cmd;
            core_start     <= 1'b1;
            catchup_active <= grant_catchup;
            if (grant_cmd == CMD_INIT) begin
              init_done <= 1'b0;
            end
`ifdef DRBG_SCHED_WATCHDOG_EN
            wd_count <= '0;
            if (grant_cmd == CMD_INIT) begin
              force_init <= 1'b0;
            end
`endif
          end
        end
        StWait: begin
          if (core_done) begin
            unique case (core_cmd)
              CMD_INIT: begin
                init_done <= 1'b1;
                seq_count <= '0;
                gen_count <= '0;
              end
              CMD_RESEED: begin
                seq_count <= seq_count + SEQ_W'(1);
                gen_count <= '0;
              end
              CMD_GEN: begin
                line_ack <= 1'b1;
                if (gen_count != GEN_MAX) begin
                  gen_count <= gen_count + GEN_W'(1);
                end
              end
              default: ;
            endcase
            state          <= StIdle;
            core_cmd       <= CMD_NONE;
            catchup_active <= 1'b0;
          end
`ifdef DRBG_SCHED_WATCHDOG_EN
          else if (wd_count == WD_LAST) begin
            // Abandon the command; the core state is now unknown.
            wd_fault       <= 1'b1;
            init_done      <= 1'b0;
            force_init     <= 1'b1;
            state          <= StIdle;
            core_cmd       <= CMD_NONE;
            catchup_active <= 1'b0;
          end else begin
            wd_count <= wd_count + WD_W'(1);
          end
`endif
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
